// File: rtl/drisc_trace_monitor.sv
// drisc retire-stream monitor: trace ring, retire count, hang/illegal halt.
// Optional load/store counters: define DRISC_TRACE_MEMOPS_EN.
module drisc_trace_monitor #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int HANG_LIMIT  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    retire,
  input  logic [ADDR_WIDTH-1:0]   pc_current,
  input  logic [ADDR_WIDTH-1:0]   pc_next,
  input  logic [6:0]              opcode,
  input  logic                    clear,
  input  logic                    trace_read,
  output logic                    trace_valid,
  output logic [ADDR_WIDTH-1:0]   trace_pc,
  output logic [6:0]              trace_opcode,
  output logic [$clog2(DEPTH):0]  trace_count,
  output logic                    trace_overflow,
  output logic [COUNT_WIDTH-1:0]  retired_count,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [ADDR_WIDTH-1:0]   halt_pc
`ifdef DRISC_TRACE_MEMOPS_EN
  ,
  output logic [COUNT_WIDTH-1:0]  load_count,
  output logic [COUNT_WIDTH-1:0]  store_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int HW = $clog2(HANG_LIMIT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [HW-1:0] HANG_PRE = HW'(HANG_LIMIT - 1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h07, 7'h13, 7'h17, 7'h23,
      7'h2f, 7'h33, 7'h37, 7'h53, 7'h63,
      7'h67, 7'h6f, 7'h73: is_legal = 1'b1;
      default:             is_legal = 1'b0;
    endcase
  endfunction

  logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
  logic [6:0]            mem_op [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [HW-1:0]         hang_run;

  logic accept, push, pop, empty, full;
  logic illegal, same, hang_hit;

  assign accept   = retire && !halted && !clear;
  assign push     = accept;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = trace_read && !empty && !clear;
  assign illegal  = !is_legal(opcode);
  assign same     = (pc_current == pc_next);
  assign hang_hit = same && (hang_run == HANG_PRE);

  assign trace_valid  = !empty;
  assign trace_count  = count;
  assign trace_pc     = empty ? '0 : mem_pc[rd_ptr];
  assign trace_opcode = empty ? '0 : mem_op[rd_ptr];

  // Trace storage; contents are masked while empty so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr] <= pc_current;
      mem_op[wr_ptr] <= opcode;
    end
  end

  // Pointers, occupancy, counters and halt state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      trace_overflow <= 1'b0;
      retired_count  <= '0;
      hang_run       <= '0;
      halted         <= 1'b0;
      halt_cause     <= 2'b00;
      halt_pc        <= '0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      trace_overflow <= 1'b0;
      retired_count  <= '0;
      hang_run       <= '0;
      halted         <= 1'b0;
      halt_cause     <= 2'b00;
      halt_pc        <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop || (push && full))
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop && full)
        trace_overflow <= 1'b1;
      if (push && !pop && !full)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (accept) begin
        if (retired_count != '1)
          retired_count <= retired_count + 1'b1;
        hang_run <= same ? hang_run + 1'b1 : '0;
        if (illegal) begin
          halted     <= 1'b1;
          halt_cause <= 2'b10;
          halt_pc    <= pc_current;
        end else if (hang_hit) begin
          halted     <= 1'b1;
          halt_cause <= 2'b01;
          halt_pc    <= pc_current;
        end
      end
    end
  end

`ifdef DRISC_TRACE_MEMOPS_EN
  logic is_load, is_store;
  assign is_load  = (opcode == 7'h03) || (opcode == 7'h07);
  assign is_store = (opcode == 7'h23) || (opcode == 7'h2f);

  // Saturating load/store counters over accepted retires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (clear) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (accept) begin
      if (is_load && load_count != '1)
        load_count <= load_count + 1'b1;
      if (is_store && store_count != '1)
        store_count <= store_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_drisc_trace_monitor.sv
// Directed bench for drisc_trace_monitor (DEPTH=16, HANG_LIMIT=3).
// Table vectors for basic fill/drain, hand sequences for corner cases.
module tb_drisc_trace_monitor;

  localparam int AW = 12;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          retire = 1'b0;
  logic [AW-1:0] pc_current = '0;
  logic [AW-1:0] pc_next = '0;
  logic [6:0]    opcode = '0;
  logic          clear = 1'b0;
  logic          trace_read = 1'b0;
  logic          trace_valid;
  logic [AW-1:0] trace_pc;
  logic [6:0]    trace_opcode;
  logic [4:0]    trace_count;
  logic          trace_overflow;
  logic [CW-1:0] retired_count;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [AW-1:0] halt_pc;
`ifdef DRISC_TRACE_MEMOPS_EN
  logic [CW-1:0] load_count;
  logic [CW-1:0] store_count;
`endif

  drisc_trace_monitor #(
    .ADDR_WIDTH(AW), .DEPTH(16),
    .COUNT_WIDTH(CW), .HANG_LIMIT(3)
  ) dut (
    .clock(clock), .reset(reset),
    .retire(retire), .pc_current(pc_current),
    .pc_next(pc_next), .opcode(opcode),
    .clear(clear), .trace_read(trace_read),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_opcode(trace_opcode),
    .trace_count(trace_count),
    .trace_overflow(trace_overflow),
    .retired_count(retired_count),
    .halted(halted), .halt_cause(halt_cause),
    .halt_pc(halt_pc)
`ifdef DRISC_TRACE_MEMOPS_EN
    ,
    .load_count(load_count),
    .store_count(store_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic r, input logic [AW-1:0] pc,
                    input logic [AW-1:0] pn, input logic [6:0] oc,
                    input logic rd, input logic clr);
    retire = r; pc_current = pc; pc_next = pn;
    opcode = oc; trace_read = rd; clear = clr;
    tick();
    retire = 0; trace_read = 0; clear = 0;
  endtask

  task automatic ret(input logic [AW-1:0] pc,
                     input logic [AW-1:0] pn,
                     input logic [6:0] oc);
    op(1, pc, pn, oc, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 64'(trace_valid), 0);
    chk({tag, ".tpc"}, 64'(trace_pc), 0);
    chk({tag, ".top"}, 64'(trace_opcode), 0);
    chk({tag, ".cnt"}, 64'(trace_count), 0);
    chk({tag, ".ovf"}, 64'(trace_overflow), 0);
    chk({tag, ".ret"}, 64'(retired_count), 0);
    chk({tag, ".halt"}, 64'(halted), 0);
    chk({tag, ".cause"}, 64'(halt_cause), 0);
    chk({tag, ".hpc"}, 64'(halt_pc), 0);
`ifdef DRISC_TRACE_MEMOPS_EN
    chk({tag, ".ld"}, 64'(load_count), 0);
    chk({tag, ".st"}, 64'(store_count), 0);
`endif
  endtask

  typedef struct {
    logic          r;
    logic [AW-1:0] pc;
    logic          rd;
    logic [4:0]    e_cnt;
    logic          e_valid;
    logic [AW-1:0] e_pc;
    logic [6:0]    e_op;
    logic [31:0]   e_ret;
  } vec_t;

  vec_t vt [11];

  initial begin
    // fill then drain; pc_next = pc + 4, opcode 13
    vt[0]  = '{1, 12'h000, 0, 1, 1, 12'h000, 7'h13, 1};
    vt[1]  = '{1, 12'h004, 0, 2, 1, 12'h000, 7'h13, 2};
    vt[2]  = '{1, 12'h008, 0, 3, 1, 12'h000, 7'h13, 3};
    vt[3]  = '{1, 12'h00c, 0, 4, 1, 12'h000, 7'h13, 4};
    vt[4]  = '{1, 12'h010, 0, 5, 1, 12'h000, 7'h13, 5};
    vt[5]  = '{0, 12'h000, 1, 4, 1, 12'h004, 7'h13, 5};
    vt[6]  = '{0, 12'h000, 1, 3, 1, 12'h008, 7'h13, 5};
    vt[7]  = '{0, 12'h000, 1, 2, 1, 12'h00c, 7'h13, 5};
    vt[8]  = '{0, 12'h000, 1, 1, 1, 12'h010, 7'h13, 5};
    vt[9]  = '{0, 12'h000, 1, 0, 0, 12'h000, 7'h00, 5};
    vt[10] = '{0, 12'h000, 1, 0, 0, 12'h000, 7'h00, 5};

    repeat (2) tick();
    chk_all_zero("rst");
    reset = 1;
    tick();

    for (int i = 0; i < 11; i++) begin
      op(vt[i].r, vt[i].pc, vt[i].pc + 12'd4, 7'h13,
         vt[i].rd, 0);
      chk($sformatf("v%0d.cnt", i), 64'(trace_count),
          64'(vt[i].e_cnt));
      chk($sformatf("v%0d.valid", i), 64'(trace_valid),
          64'(vt[i].e_valid));
      chk($sformatf("v%0d.tpc", i), 64'(trace_pc),
          64'(vt[i].e_pc));
      chk($sformatf("v%0d.top", i), 64'(trace_opcode),
          64'(vt[i].e_op));
      chk($sformatf("v%0d.ret", i), 64'(retired_count),
          64'(vt[i].e_ret));
    end
    chk("v.ovf", 64'(trace_overflow), 0);

    // 20 retires overwrite the 4 oldest
    op(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      ret(12'(i * 4), 12'(i * 4 + 4), 7'h13);
    chk("ovr.cnt", 64'(trace_count), 16);
    chk("ovr.ovf", 64'(trace_overflow), 1);
    chk("ovr.ret", 64'(retired_count), 20);
    chk("ovr.tpc", 64'(trace_pc), 12'h010);
    // full: push + pop together
    op(1, 12'h050, 12'h054, 7'h13, 1, 0);
    chk("pp.cnt", 64'(trace_count), 16);
    chk("pp.ovf", 64'(trace_overflow), 1);
    chk("pp.tpc", 64'(trace_pc), 12'h014);
    chk("pp.ret", 64'(retired_count), 21);

    // exactly full, push + pop must not flag overflow
    op(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      ret(12'(i * 4), 12'(i * 4 + 4), 7'h13);
    chk("full.cnt", 64'(trace_count), 16);
    chk("full.ovf", 64'(trace_overflow), 0);
    op(1, 12'h100, 12'h104, 7'h13, 1, 0);
    chk("fpp.cnt", 64'(trace_count), 16);
    chk("fpp.ovf", 64'(trace_overflow), 0);
    chk("fpp.tpc", 64'(trace_pc), 12'h004);

    // hang run broken by an advancing retire
    op(0, 0, 0, 0, 0, 1);
    ret(12'h040, 12'h040, 7'h13);
    ret(12'h040, 12'h040, 7'h13);
    ret(12'h040, 12'h044, 7'h13);
    ret(12'h044, 12'h044, 7'h13);
    ret(12'h044, 12'h044, 7'h13);
    chk("hrun.halt", 64'(halted), 0);
    chk("hrun.ret", 64'(retired_count), 5);

    // hang after 3 non-advancing retires
    op(0, 0, 0, 0, 0, 1);
    ret(12'h040, 12'h040, 7'h13);
    ret(12'h040, 12'h040, 7'h13);
    chk("hang2.halt", 64'(halted), 0);
    ret(12'h040, 12'h040, 7'h13);
    chk("hang.halt", 64'(halted), 1);
    chk("hang.cause", 64'(halt_cause), 1);
    chk("hang.hpc", 64'(halt_pc), 12'h040);
    chk("hang.ret", 64'(retired_count), 3);
    chk("hang.cnt", 64'(trace_count), 3);
    ret(12'h080, 12'h084, 7'h13);
    chk("hold.ret", 64'(retired_count), 3);
    chk("hold.cnt", 64'(trace_count), 3);
    op(0, 0, 0, 0, 1, 0);
    chk("hrd.cnt", 64'(trace_count), 2);
    chk("hrd.halt", 64'(halted), 1);

    // illegal opcode
    op(0, 0, 0, 0, 0, 1);
    ret(12'h020, 12'h024, 7'h7f);
    chk("ill.halt", 64'(halted), 1);
    chk("ill.cause", 64'(halt_cause), 2);
    chk("ill.hpc", 64'(halt_pc), 12'h020);
    chk("ill.ret", 64'(retired_count), 1);
    chk("ill.top", 64'(trace_opcode), 7'h7f);

    // illegal and hang on the same retire: illegal wins
    op(0, 0, 0, 0, 0, 1);
    ret(12'h060, 12'h060, 7'h13);
    ret(12'h060, 12'h060, 7'h13);
    ret(12'h060, 12'h060, 7'h05);
    chk("both.cause", 64'(halt_cause), 2);
    chk("both.hpc", 64'(halt_pc), 12'h060);

    // clear from a halted, populated state
    op(0, 0, 0, 0, 0, 1);
    chk_all_zero("clr");

`ifdef DRISC_TRACE_MEMOPS_EN
    ret(12'h000, 12'h004, 7'h03);
    ret(12'h004, 12'h008, 7'h23);
    ret(12'h008, 12'h00c, 7'h23);
    ret(12'h00c, 12'h010, 7'h33);
    chk("mem.ld", 64'(load_count), 1);
    chk("mem.st", 64'(store_count), 2);
    op(0, 0, 0, 0, 0, 1);
    chk_all_zero("mclr");
`endif

    // clear beats retire in the same cycle
    op(1, 12'h010, 12'h014, 7'h13, 0, 1);
    chk("cpri.cnt", 64'(trace_count), 0);
    chk("cpri.ret", 64'(retired_count), 0);

    // async reset mid-operation
    for (int i = 0; i < 7; i++)
      ret(12'(i * 4), 12'(i * 4 + 4), 7'h13);
    chk("pre.cnt", 64'(trace_count), 7);
    #2;
    reset = 0;
    #1;
    chk_all_zero("arst");
    tick();
    reset = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
